// File: rtl/ttu_pkg.sv
// Shared encodings for the target tracking unit: scheduler states, the TTU's
// own status encoding and the default distance width.
package ttu_pkg;

    localparam int TTU_DIST_W = 14;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ISSUE   = 2'b01,
        S_WAIT    = 2'b10,
        S_HOLDOFF = 2'b11
    } sched_state_e;

    // Status encoding reported by the TTU itself.
    typedef enum logic [1:0] {
        TTU_IDLE     = 2'b00,
        TTU_SEARCH   = 2'b01,
        TTU_LOCKED   = 2'b10,
        TTU_FAULT    = 2'b11
    } ttu_state_e;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: rise_o is high in the cycle d_i goes 0->1 relative
// to the value registered at the previous clock edge.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge clk) begin
        if (rst) prev_q <= 1'b0;
        else     prev_q <= d_i;
    end

    assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/ttu_track_scheduler.sv
// Revisit scheduler for the TTU: issues periodic track commands, waits a
// bounded window for a lock edge, captures range and tracks consecutive misses.
module ttu_track_scheduler
    import ttu_pkg::*;
#(
    parameter int PERIOD_CYCLES  = 50,
    parameter int TIMEOUT_CYCLES = 40,
    parameter int MAX_MISSES     = 3,
    parameter int DIST_W         = TTU_DIST_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_tracking,
    input  logic              stop_tracking,
    input  logic              ttu_target_locked,
    input  logic [DIST_W-1:0] ttu_distance,
    output logic              track_target_command,
    output logic [DIST_W-1:0] target_distance,
    output logic              distance_valid,
    output logic [DIST_W:0]   range_delta,
    output logic              closing,
    output logic              target_lost,
    output logic [2:0]        miss_count,
    output logic [1:0]        sched_state
);

    localparam int PW = $clog2(PERIOD_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    sched_state_e      state_q, state_d;
    logic              cmd_q;
    logic [PW-1:0]     pcnt_q;
    logic [TW-1:0]     tcnt_q;
    logic [DIST_W-1:0] dist_q;
    logic              dv_q;
    logic [DIST_W:0]   delta_q;
    logic              closing_q;
    logic              lost_q;
    logic [2:0]        miss_q;

    logic              lock_edge;
    logic              hit, miss;
    logic [2:0]        miss_inc;

    rise_detect u_lock_edge (
        .clk    (clk),
        .rst    (rst),
        .d_i    (ttu_target_locked),
        .rise_o (lock_edge)
    );

    assign miss_inc = (miss_q == 3'(MAX_MISSES)) ? miss_q : miss_q + 3'd1;

    always_comb begin
        state_d = state_q;
        hit     = 1'b0;
        miss    = 1'b0;
        unique case (state_q)
            S_IDLE:    if (start_tracking && !stop_tracking) state_d = S_ISSUE;
            S_ISSUE:   state_d = S_WAIT;
            // tcnt_q = k-1 on WAIT cycle k, so every WAIT cycle is inside the window
            S_WAIT: begin
                if (lock_edge) begin
                    hit     = 1'b1;
                    state_d = S_HOLDOFF;
                end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    miss    = 1'b1;
                    state_d = (miss_inc == 3'(MAX_MISSES)) ? S_IDLE : S_HOLDOFF;
                end
            end
            S_HOLDOFF: if (pcnt_q == PW'(PERIOD_CYCLES - 1)) state_d = S_ISSUE;
        endcase
        if (stop_tracking && state_q != S_IDLE) begin
            state_d = S_IDLE;
            hit     = 1'b0;
            miss    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cmd_q     <= 1'b0;
            pcnt_q    <= '0;
            tcnt_q    <= '0;
            dist_q    <= '0;
            dv_q      <= 1'b0;
            delta_q   <= '0;
            closing_q <= 1'b0;
            lost_q    <= 1'b0;
            miss_q    <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= (state_d == S_ISSUE);

            // Period counts from the ISSUE cycle itself, giving exactly PERIOD_CYCLES between pulses
            if (state_d == S_ISSUE)      pcnt_q <= '0;
            else if (state_q != S_IDLE)  pcnt_q <= pcnt_q + PW'(1);

            tcnt_q <= (state_q == S_WAIT) ? tcnt_q + TW'(1) : '0;

            if (state_q == S_IDLE && state_d == S_ISSUE) begin
                miss_q    <= '0;
                dv_q      <= 1'b0;
                closing_q <= 1'b0;
                delta_q   <= '0;
                lost_q    <= 1'b0;
            end

            if (hit) begin
                dist_q <= ttu_distance;
                if (dv_q) begin
                    delta_q   <= {1'b0, ttu_distance} - {1'b0, dist_q};
                    closing_q <= (ttu_distance < dist_q);
                end
                dv_q   <= 1'b1;
                miss_q <= '0;
            end

            if (miss) begin
                miss_q <= miss_inc;
                if (miss_inc == 3'(MAX_MISSES)) begin
                    lost_q <= 1'b1;
                    dv_q   <= 1'b0;
                end
            end
        end
    end

    assign track_target_command = cmd_q;
    assign target_distance      = dist_q;
    assign distance_valid       = dv_q;
    assign range_delta          = delta_q;
    assign closing              = closing_q;
    assign target_lost          = lost_q;
    assign miss_count           = miss_q;
    assign sched_state          = state_q;

endmodule
